// File: rtl/btn_debounce_repeat.sv
// Multi-channel push-button front end: sync, two-way debounce,
// press/release/auto-repeat pulses and a lowest-index event encoder.
module btn_debounce_repeat #(
    parameter int N_BTN           = 4,
    parameter int DB_W            = 12,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int RPT_W           = 24,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 1_000_000,
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level_out,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] event_pulse,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEATING,
        RELEASE_WAIT
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    // Two-flop synchroniser, free-running regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [DB_W-1:0]  db_q, db_d;
        logic [RPT_W-1:0] rc_q, rc_d, rc_lim;
        logic             rep_q, rep_d;
        logic             lvl_q, lvl_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             rpt_q, rpt_d;
        logic             evt_q;
        logic             fire;

        // Channel state, counters and registered pulses
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                db_q    <= '0;
                rc_q    <= '0;
                rep_q   <= 1'b0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rpt_q   <= 1'b0;
                evt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                db_q    <= db_d;
                rc_q    <= rc_d;
                rep_q   <= rep_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                rpt_q   <= rpt_d;
                evt_q   <= press_d | rpt_d;
            end
        end

        // Debounce FSM and repeat timer; rep_q remembers the
        // repeating phase across a release glitch
        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            rc_d    = rc_q;
            rep_d   = rep_q;
            lvl_d   = lvl_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            rpt_d   = 1'b0;
            fire    = 1'b0;
            rc_lim  = rep_q ? PER_LAST : DLY_LAST;
            if (ena) begin
                if (lvl_q) begin
                    if (!repeat_en[i]) begin
                        rc_d  = '0;
                        rep_d = 1'b0;
                    end else if (rc_q == rc_lim) begin
                        fire  = 1'b1;
                        rc_d  = '0;
                        rep_d = 1'b1;
                    end else begin
                        rc_d = rc_q + RPT_W'(1);
                    end
                end
                unique case (state_q)
                    IDLE: begin
                        if (sync2[i]) begin
                            state_d = PRESS_WAIT;
                            db_d    = DB_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2[i]) begin
                            state_d = IDLE;
                            db_d    = '0;
                        end else if (db_q == DB_LAST) begin
                            state_d = HELD;
                            db_d    = '0;
                            lvl_d   = 1'b1;
                            press_d = 1'b1;
                            rc_d    = '0;
                            rep_d   = 1'b0;
                        end else begin
                            db_d = db_q + DB_W'(1);
                        end
                    end
                    HELD, REPEATING: begin
                        if (!sync2[i]) begin
                            state_d = RELEASE_WAIT;
                            db_d    = DB_W'(1);
                        end else begin
                            state_d = rep_d ? REPEATING : HELD;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2[i]) begin
                            state_d = rep_d ? REPEATING : HELD;
                            db_d    = '0;
                        end else if (db_q == DB_LAST) begin
                            state_d = IDLE;
                            db_d    = '0;
                            lvl_d   = 1'b0;
                            rel_d   = 1'b1;
                            rc_d    = '0;
                            rep_d   = 1'b0;
                            fire    = 1'b0;
                        end else begin
                            db_d = db_q + DB_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        db_d    = '0;
                    end
                endcase
                rpt_d = fire;
            end
        end

        assign level_out[i]     = lvl_q;
        assign press_pulse[i]   = press_q & ena;
        assign release_pulse[i] = rel_q & ena;
        assign repeat_pulse[i]  = rpt_q & ena;
        assign event_pulse[i]   = evt_q & ena;
    end

    assign evt_valid = |event_pulse;

    // Lowest set channel wins
    always_comb begin
        evt_idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (event_pulse[k]) evt_idx = IDX_W'(k);
        end
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat with short debounce/repeat
// timings; expected pulse cycles are computed from the timing rules.
module tb_btn_debounce_repeat;

    localparam int NB  = 4;
    localparam int DB  = 8;
    localparam int DLY = 20;
    localparam int PER = 5;
    localparam int LAT = DB + 2;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] level_out;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] repeat_pulse;
    logic [NB-1:0] event_pulse;
    logic          evt_valid;
    logic [1:0]    evt_idx;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce_repeat #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .event_pulse  (event_pulse),
        .evt_valid    (evt_valid),
        .evt_idx      (evt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return {level_out, press_pulse, release_pulse, repeat_pulse,
                event_pulse, evt_valid, evt_idx};
    endfunction

    // Hold one channel from cycle 0, release at fall_c, check each cycle
    task automatic run_seq(input int ch, input int fall_c, input bit ren,
                           input int ncyc);
        logic [7:0] got, exp;
        logic       lv, p, r, rp, ev;
        int         rel_c;
        rel_c = fall_c + LAT;
        repeat_en[ch] = ren;
        btn_in[ch] = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            lv = (c >= LAT) && (c < rel_c);
            p  = (c == LAT);
            r  = (c == rel_c);
            rp = ren && (c >= LAT + DLY) && (c < rel_c)
                 && (((c - LAT - DLY) % PER) == 0);
            ev = p | rp;
            exp = {lv, p, r, rp, ev, ev, ev ? 2'(ch) : 2'd0};
            got = {level_out[ch], press_pulse[ch], release_pulse[ch],
                   repeat_pulse[ch], event_pulse[ch], evt_valid, evt_idx};
            check($sformatf("seq ch%0d c%0d", ch, c), 32'(got), 32'(exp));
            if (c == fall_c) btn_in[ch] = 1'b0;
        end
        repeat_en[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        ena       = 1'b1;
        btn_in    = '0;
        repeat_en = '0;
        #3;
        check("reset outputs", all_out(), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle after reset", all_out(), 32'd0);

        // clean press/release, no repeat
        run_seq(0, 40, 1'b0, 55);
        // auto-repeat, release debounced at cycle 47
        run_seq(2, 37, 1'b1, 55);
        // release completes on a repeat-expiry cycle
        run_seq(2, 40, 1'b1, 60);

        // glitch rejection on channel 1
        btn_in[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check($sformatf("glitch c%0d", c),
                  32'({level_out[1], press_pulse[1]}),
                  32'({c >= 18, c == 18}));
            if (c == 7) btn_in[1] = 1'b0;
            if (c == 8) btn_in[1] = 1'b1;
        end
        btn_in[1] = 1'b0;
        repeat (LAT) tick();
        check("glitch release", 32'(release_pulse), 32'b0010);
        repeat (3) tick();

        // simultaneous press on 1 and 3, repeat disabled
        btn_in = 4'b1010;
        repeat (LAT - 1) tick();
        check("prio pre valid", 32'(evt_valid), 32'd0);
        tick();
        check("prio event", 32'(event_pulse), 32'b1010);
        check("prio press", 32'(press_pulse), 32'b1010);
        check("prio valid", 32'(evt_valid), 32'd1);
        check("prio idx", 32'(evt_idx), 32'd1);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (repeat_pulse != 0 || event_pulse != 0) seen++;
        end
        check("prio no repeat", 32'(seen), 32'd0);
        check("prio level", 32'(level_out), 32'b1010);
        btn_in = '0;
        repeat (LAT) tick();
        check("prio release", 32'(release_pulse), 32'b1010);
        repeat (3) tick();

        // ena freeze at debounce count 4
        btn_in[0] = 1'b1;
        repeat (6) tick();
        ena = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if ({level_out, press_pulse, event_pulse, evt_valid} != 0)
                seen++;
        end
        check("freeze quiet", 32'(seen), 32'd0);
        ena = 1'b1;
        repeat (3) tick();
        check("resume early", 32'({level_out, press_pulse}), 32'd0);
        tick();
        check("resume press", 32'(press_pulse), 32'b0001);
        check("resume level", 32'(level_out), 32'b0001);
        tick();
        check("held level", 32'(level_out), 32'b0001);

        // async reset with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", all_out(), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check($sformatf("post rst c%0d", c),
                  32'({level_out[0], press_pulse[0]}),
                  32'({c == LAT, c == LAT}));
        end
        btn_in = '0;
        repeat (LAT) tick();
        check("final release", 32'(release_pulse), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_repeat.md
# btn_debounce_repeat

Parametrised multi-channel push-button front end for the seven-segment animation designs. It replaces the per-button hand-written debounce counters. Each channel synchronises a raw `ui_in` button bit and debounces it in both directions. Each channel also emits single-cycle press, release and auto-repeat pulses, and a priority-encoded event index. Animation-select and speed-control FSMs consume those outputs directly.

## Interface
- `N_BTN`, 4: number of button channels.
- `DB_W`, 12: debounce counter width.
- `DEBOUNCE_CYCLES`, 512: consecutive stable synchronised samples required to change level. Range 2..2^DB_W−1.
- `RPT_W`, 24: repeat counter width.
- `REPEAT_DELAY`, 5_000_000: cycles from press pulse to first repeat pulse. Range 1..2^RPT_W−1.
- `REPEAT_PERIOD`, 1_000_000: cycles between subsequent repeat pulses. Range 1..REPEAT_DELAY.
- `clk`, in, 1: single clock for all logic.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ena`, in, 1: high = run. Low = freeze counters and levels, and force all pulses to 0.
- `btn_in`, in, N_BTN: raw asynchronous buttons, active-high.
- `repeat_en`, in, N_BTN: per-channel auto-repeat enable.
- `level_out`, out, N_BTN: debounced level.
- `press_pulse`, out, N_BTN: one-cycle pulse on a debounced rising edge.
- `release_pulse`, out, N_BTN: one-cycle pulse on a debounced falling edge.
- `repeat_pulse`, out, N_BTN: one-cycle auto-repeat pulse.
- `event_pulse`, out, N_BTN: press_pulse | repeat_pulse, registered.
- `evt_valid`, out, 1: |event_pulse.
- `evt_idx`, out, max(1, ceil(log2 N_BTN)): lowest-index channel with event_pulse set. 0 when evt_valid = 0.

## Operation
- **Synchroniser:** 2-flop synchroniser per channel, output `s[i]`. It runs regardless of `ena`.
- **Per-channel FSM states:**
  - IDLE: level 0, stable.
  - PRESS_WAIT: `s`=1, counting toward press.
  - HELD: level 1, repeat counter running toward REPEAT_DELAY.
  - REPEATING: level 1, repeat counter running toward REPEAT_PERIOD.
  - RELEASE_WAIT: `s`=0 while level 1.
- **Debounce counter:**
  - In IDLE/HELD/REPEATING, `s` ≠ level moves the channel to PRESS_WAIT/RELEASE_WAIT with count = 1.
  - In a WAIT state, each cycle with `s` ≠ level increments the count.
  - Any cycle with `s` = level clears the count and returns to the prior stable state. A glitch therefore restarts debounce completely.
  - In RELEASE_WAIT the repeat counter keeps running.
- **Level change:** when the count would reach DEBOUNCE_CYCLES, level toggles on that edge.
  - Rise: go to HELD, repeat counter := 0.
  - Fall: go to IDLE.
- **Press/release pulses:** press_pulse (rise) or release_pulse (fall) is high in the first cycle the new level is visible, for exactly one cycle.
- **Repeat, with `repeat_en[i]`=1 and level 1:**
  - Repeat counter increments each cycle.
  - In HELD, reaching REPEAT_DELAY asserts repeat_pulse, clears the counter and enters REPEATING.
  - In REPEATING, reaching REPEAT_PERIOD asserts repeat_pulse and clears the counter.
- **repeat_en[i]=0:** repeat counter held at 0, no repeat pulses, state returns to HELD.
  - Re-enabling restarts the full REPEAT_DELAY from that cycle.
- **Simultaneous release and repeat expiry:** if release debounce completes on the same cycle a repeat would fire, release wins. No repeat_pulse is issued, and none is issued after the release.
- **ena=0:**
  - All debounce and repeat counters and FSM states hold.
  - All pulse outputs and evt_valid are 0; level_out holds.
  - Pulses that would have fired are dropped, not deferred.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels all appear in event_pulse; evt_idx reports the lowest index.
- **Reset:** all outputs 0, synchroniser flops 0, all counters 0, all FSMs in IDLE.

## Timing
- **Raw press to level_out and press_pulse:** 2 sync cycles + DEBOUNCE_CYCLES. This holds when the raw input is clean.
- **Release latency:** identical to press latency.
- **First repeat_pulse:** REPEAT_DELAY cycles after the press_pulse cycle. Subsequent repeat pulses are every REPEAT_PERIOD cycles.
- **Output registers:** pulse, level and event_pulse are registered.
- **Combinational outputs:** evt_valid and evt_idx are combinational from registered event_pulse (zero added latency).
- **Reset assertion:** asynchronous; outputs go to 0 immediately, independent of clk.
- **Reset deassertion:** first synchroniser capture on the first clk edge after deassertion.
- **Reset mid-press:** clears all state. A button still held after reset requires a full debounce again and produces a fresh press_pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BTN=4, ena=1.

- **Clean press/release:** btn_in[0] high at cycle 0 → level_out[0] and press_pulse[0] at cycle 10, press_pulse one cycle wide. Release at cycle 40 → release_pulse[0] at cycle 50, level 0.
- **Glitch rejection:** btn_in[1] high 7 cycles, low 1 cycle, high again → no press at cycle 9. press_pulse[1] at 10 cycles after the second rise.
- **Auto-repeat:** repeat_en[2]=1, hold btn 2 → press at cycle 10, repeats at cycles 30, 35, 40, 45. Release debounced at cycle 47 → no further repeats; release_pulse at 47.
- **Release beats repeat:** time the release debounce to complete on a repeat-expiry cycle → release_pulse only, repeat_pulse stays 0.
- **Priority encode:** channels 1 and 3 press on the same cycle → event_pulse=4'b1010, evt_valid=1, evt_idx=1. repeat_en=0 → no repeats after 100 cycles of hold.
- **ena freeze and async reset:** drop ena at debounce count 4 for 50 cycles → pulses stay 0; press fires 4 cycles after ena returns. Assert rst_n=0 while level_out=1 → all outputs 0 with no clk edge.
